// File: rtl/week5_ex2_nand_checker.sv
// Synthesizable stimulus/check sequencer for a 2-input NAND: drives 00,01,10,11, samples y after a settle delay.
// Build option: define NAND_CHK_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module week5_ex2_nand_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] pass_cnt,
    output logic [2:0] fail_cnt,
    output logic [1:0] fail_idx,
    output logic       all_pass
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] SCNT_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] pass_cnt_q, pass_cnt_d;
    logic [2:0] fail_cnt_q, fail_cnt_d;
    logic [1:0] fail_idx_q, fail_idx_d;
    logic       expected;
    logic       stop_run;

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        scnt_d     = scnt_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        fail_idx_d = fail_idx_q;
        expected   = ~(idx_q[1] & idx_q[0]);
        stop_run   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // IDLE keeps everything cleared; DONE holds results until a restart.
                if (state_q == ST_IDLE || start) begin
                    idx_d      = '0;
                    scnt_d     = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    fail_idx_d = '0;
                end
                if (start) begin
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (scnt_q == SCNT_LAST) begin
                    scnt_d  = '0;
                    state_d = ST_CHECK;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end

            ST_CHECK: begin
                stop_run = (idx_q == 2'd3);
                // Equality selects the pass branch, so an unknown y_in lands in the fail branch.
                if (y_in == expected) begin
                    pass_cnt_d = pass_cnt_q + 3'd1;
                end else begin
                    fail_cnt_d = fail_cnt_q + 3'd1;
                    if (fail_cnt_q == 3'd0) begin
                        fail_idx_d = idx_q;
                    end
`ifdef NAND_CHK_STOP_ON_FAIL_EN
                    stop_run = 1'b1;
`endif
                end
                if (stop_run) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_SETTLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            scnt_q     <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            scnt_q     <= scnt_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    assign a_out    = idx_q[1];
    assign b_out    = idx_q[0];
    assign busy     = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done     = (state_q == ST_DONE);
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign fail_idx = fail_idx_q;
    assign all_pass = done && (pass_cnt_q == 3'd4);

endmodule
